if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID stage.
- Owns the PC and drives a single-outstanding req/gnt/rvalid instruction-memory port.
- Presents instruction and pc_ID to ID.
- Stalls on hazard_detected; redirects and flushes on brTaken/br_target from ID.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_if.sv | 34 +++
 rtl/if_id_reg.sv | 47 ++++
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: fetch FSM state enum, default word/address widths, bubble encoding.
package if_stage_pkg;

    localparam int IF_WORD_LEN = 16;
    localparam int IF_ADDR_W = 16;

    // Bubble presented to ID after reset or a flush.
    localparam logic [IF_WORD_LEN-1:0] IF_NOP_INSTR = '0;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // request outstanding on the port, addr = pc
        S_WAIT = 2'd1,   // granted, waiting for rvalid
        S_HOLD = 2'd2    // data returned during a stall, parked in hold buffer
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory port, single outstanding req/gnt/rvalid.
// Latency: gnt in the request cycle at the earliest, rvalid one cycle after gnt at the earliest.
// Backpressure: memory withholds gnt; addr must stay stable while req is high without gnt.
// Signals: req/addr from fetch, gnt/rvalid/rdata from memory. master = fetch side, slave = memory side.
interface if_stage_if
    import if_stage_pkg::*;
#(
    parameter int ADDR_W   = IF_ADDR_W,
    parameter int WORD_LEN = IF_WORD_LEN
) ();

    logic                req;
    logic [ADDR_W-1:0]   addr;
    logic                gnt;
    logic                rvalid;
    logic [WORD_LEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register holding instruction, its pc and a valid bit.
// Latency: one cycle, loads on the edge where load_i is high.
// Backpressure: hold_i freezes contents; flush_i overrides both and inserts a bubble.
// Ports: clk, rst (async active-low), load_i/flush_i/hold_i controls, instr_i/pc_i data in,
//        instr_o/pc_o/valid_o to ID.
module if_id_reg #(
    parameter int                  WORD_LEN  = 16,
    parameter int                  ADDR_W    = 16,
    parameter logic [WORD_LEN-1:0] NOP_INSTR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                flush_i,
    input  logic                hold_i,
    input  logic [WORD_LEN-1:0] instr_i,
    input  logic [ADDR_W-1:0]   pc_i,
    output logic [WORD_LEN-1:0] instr_o,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                valid_o
);

    logic [WORD_LEN-1:0] instr_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                valid_q;

    // Priority: flush > hold > load. pc is left as-is on a flush; valid_q marks it stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i && !hold_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: owns the PC, fetches over a single-outstanding imem port and feeds the IF/ID register.
// Latency: gnt in the request cycle + rvalid next cycle; IF/ID loads on the rvalid edge (peak 1 instr / 2 cycles).
// Backpressure: hazard_detected freezes PC and IF/ID, a returning word parks in a hold buffer; brTaken redirects and flushes.
// Ports: clk, rst (async active-low), hazard_detected, brTaken/br_target from ID, imem (master),
//        instruction/pc_ID/instr_valid to ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                  WORD_LEN  = IF_WORD_LEN,
    parameter int                  ADDR_W    = IF_ADDR_W,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [WORD_LEN-1:0] NOP_INSTR = WORD_LEN'(IF_NOP_INSTR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard_detected,
    input  logic                brTaken,
    input  logic [ADDR_W-1:0]   br_target,
    if_stage_if.master          imem,
    output logic [WORD_LEN-1:0] instruction,
    output logic [ADDR_W-1:0]   pc_ID,
    output logic                instr_valid
);

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_inc_d;
    logic                kill_q;
    logic [WORD_LEN-1:0] hold_buf_q;

    logic                mem_fill;
    logic                hold_fill;
    logic [WORD_LEN-1:0] fill_instr;

    // Wraps modulo 2^ADDR_W.
    assign pc_inc_d = pc_q + ADDR_W'(1);

    // Gated by rst so the port is quiet during reset yet requests in the very first cycle after release.
    assign imem.req  = rst && (state_q == S_REQ);
    assign imem.addr = pc_q;

    // Candidate IF/ID loads; if_id_reg applies flush (brTaken) and hold (hazard) on top of these.
    assign mem_fill   = (state_q == S_WAIT) && imem.rvalid && !kill_q;
    assign hold_fill  = (state_q == S_HOLD);
    assign fill_instr = hold_fill ? hold_buf_q : imem.rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            hold_buf_q <= NOP_INSTR;
        end else if (brTaken) begin
            // Redirect wins over stalls and over any response arriving this cycle.
            pc_q <= br_target;
            case (state_q)
                S_REQ: begin
                    if (imem.gnt) begin
                        // Request already accepted: its response must be dropped.
                        kill_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        kill_q  <= 1'b0;
                        state_q <= S_REQ;
                    end else begin
                        kill_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem.gnt) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (!hazard_detected) begin
                            pc_q    <= pc_inc_d;
                            state_q <= S_REQ;
                        end else begin
                            hold_buf_q <= imem.rdata;
                            state_q    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!hazard_detected) begin
                        pc_q    <= pc_inc_d;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    if_id_reg #(
        .WORD_LEN  (WORD_LEN),
        .ADDR_W    (ADDR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (mem_fill || hold_fill),
        .flush_i (brTaken),
        .hold_i  (hazard_detected),
        .instr_i (fill_instr),
        .pc_i    (pc_q),
        .instr_o (instruction),
        .pc_o    (pc_ID),
        .valid_o (instr_valid)
    );

    // A response is only legal while a fetch is outstanding.
    rvalid_only_in_wait: assert property (@(posedge clk) disable iff (!rst)
        imem.rvalid |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage with a transaction-level fetch model and a memory responder.
// Latency: n/a.
// Backpressure: responder can delay gnt (gnt_wait) and rvalid (rv_wait).
module tb_if_stage;

    localparam int AW = 16;
    localparam int WL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hazard_detected;
    logic          brTaken;
    logic [AW-1:0] br_target;
    logic [WL-1:0] instruction;
    logic [AW-1:0] pc_ID;
    logic          instr_valid;

    if_stage_if #(.ADDR_W(AW), .WORD_LEN(WL)) imem ();

    if_stage #(
        .WORD_LEN  (WL),
        .ADDR_W    (AW),
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .brTaken         (brTaken),
        .br_target       (br_target),
        .imem            (imem),
        .instruction     (instruction),
        .pc_ID           (pc_ID),
        .instr_valid     (instr_valid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory responder: data = addr + 16'h1000 ----------------
    int            gnt_wait = 0;
    int            rv_wait  = 0;
    int            wcnt     = 0;
    int            rcnt     = 0;
    bit            pend     = 0;
    bit            inject   = 0;
    bit            r_granted;
    logic [AW-1:0] r_gaddr;
    logic [AW-1:0] paddr;

    initial begin
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        paddr       = '0;
        forever begin
            @(posedge clk);
            r_granted = rst && imem.req && imem.gnt;
            r_gaddr   = imem.addr;
            #1;
            if (!rst) begin
                pend        = 0;
                wcnt        = 0;
                imem.gnt    = 1'b0;
                imem.rvalid = inject;
                imem.rdata  = 16'hDEAD;
            end else begin
                imem.rvalid = 1'b0;
                if (r_granted) begin
                    pend  = 1;
                    paddr = r_gaddr;
                    rcnt  = rv_wait;
                end
                if (pend) begin
                    if (rcnt == 0) begin
                        imem.rvalid = 1'b1;
                        imem.rdata  = paddr + 16'h1000;
                        pend        = 0;
                    end else begin
                        rcnt--;
                    end
                end
                imem.gnt = 1'b0;
                if (imem.req && !pend) begin
                    if (wcnt >= gnt_wait) begin
                        imem.gnt = 1'b1;
                        wcnt     = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // ---------------- transaction-level fetch model ----------------
    // m_req: next fetch waiting to be issued at m_pc; m_out: one fetch in flight (m_dead = its data is stale);
    // m_held: returned word waiting out a stall. e_*: what ID must see.
    logic [AW-1:0] m_pc, m_out_addr, m_held_addr, e_pc;
    logic [WL-1:0] m_held_dat, e_instr;
    bit            m_req, m_out, m_dead, m_held, e_valid;

    task automatic deliver(input logic [WL-1:0] d, input logic [AW-1:0] a);
        e_instr = d;
        e_pc    = a;
        e_valid = 1'b1;
        m_pc    = a + 16'd1;
        m_req   = 1'b1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 16'h0000; m_req = 1'b1; m_out = 1'b0; m_dead = 1'b0; m_held = 1'b0;
            m_out_addr = '0; m_held_addr = '0; m_held_dat = '0;
            e_instr = 16'h0000; e_pc = 16'h0000; e_valid = 1'b0;
        end else if (brTaken) begin
            e_instr = 16'h0000;
            e_valid = 1'b0;
            m_pc    = br_target;
            m_held  = 1'b0;
            if (m_req && imem.gnt) begin
                m_req = 1'b0; m_out = 1'b1; m_dead = 1'b1;
            end else if (m_out && !imem.rvalid) begin
                m_dead = 1'b1;
            end else begin
                m_out = 1'b0; m_req = 1'b1;
            end
        end else if (m_req) begin
            if (imem.gnt) begin
                m_req = 1'b0; m_out = 1'b1; m_dead = 1'b0; m_out_addr = m_pc;
            end
        end else if (m_out) begin
            if (imem.rvalid) begin
                m_out = 1'b0;
                if (m_dead) begin
                    m_req = 1'b1;
                end else if (hazard_detected) begin
                    m_held = 1'b1; m_held_dat = imem.rdata; m_held_addr = m_out_addr;
                end else begin
                    deliver(imem.rdata, m_out_addr);
                end
            end
        end else if (m_held && !hazard_detected) begin
            m_held = 1'b0;
            deliver(m_held_dat, m_held_addr);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk1("req", imem.req, rst && m_req);
            if (rst && m_req) chk16("addr", imem.addr, m_pc);
            chk16("instruction", instruction, e_instr);
            chk16("pc_ID", pc_ID, e_pc);
            chk1("instr_valid", instr_valid, e_valid);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [AW-1:0] a);
        bit hit;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            hit = imem.req && imem.gnt && (imem.addr == a);
            #1;
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_grant: no grant of %h within 50 cycles", a);
        end
    endtask

    task automatic chk_ifid(input string nm, input logic [15:0] ins, input logic [15:0] pc, input logic v);
        chk16({nm, "_instr"}, instruction, ins);
        chk16({nm, "_pc"}, pc_ID, pc);
        chk1({nm, "_valid"}, instr_valid, v);
    endtask

    initial begin
        hazard_detected = 1'b0;
        brTaken         = 1'b0;
        br_target       = '0;

        // Reset state
        @(negedge clk);
        chk_ifid("reset", 16'h0000, 16'h0000, 1'b0);
        chk1("reset_req", imem.req, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk1("first_req", imem.req, 1'b1);
        chk16("first_addr", imem.addr, 16'h0000);

        // Zero-wait stream: one instruction every 2 cycles
        @(negedge clk); chk1("pre_load_valid0", instr_valid, 1'b0);
        @(negedge clk); chk1("pre_load_valid1", instr_valid, 1'b0);
        @(negedge clk); chk_ifid("stream0", 16'h1000, 16'h0000, 1'b1);
        @(negedge clk); chk_ifid("stream0_hold", 16'h1000, 16'h0000, 1'b1);
        @(negedge clk); chk_ifid("stream1", 16'h1001, 16'h0001, 1'b1);
        @(negedge clk); chk_ifid("stream1_hold", 16'h1001, 16'h0001, 1'b1);
        @(negedge clk); chk_ifid("stream2", 16'h1002, 16'h0002, 1'b1);

        // Stall for 3 cycles while the pc=5 fetch completes
        wait_grant(16'h0005);
        hazard_detected = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_ifid("stall", 16'h1004, 16'h0004, 1'b1);
            chk1("stall_no_req", imem.req, 1'b0);
            tick();
        end
        hazard_detected = 1'b0;
        @(negedge clk);
        chk_ifid("stall_last", 16'h1004, 16'h0004, 1'b1);
        chk1("hold_no_req", imem.req, 1'b0);
        @(negedge clk);
        chk_ifid("after_stall", 16'h1005, 16'h0005, 1'b1);

        // Branch while waiting; stale response 2 cycles later is dropped
        rv_wait = 2;
        wait_grant(16'h0006);
        brTaken   = 1'b1;
        br_target = 16'h0040;
        tick();
        brTaken = 1'b0;
        rv_wait = 0;
        @(negedge clk); chk_ifid("flush", 16'h0000, 16'h0005, 1'b0);
        @(negedge clk); chk1("stale_pending_valid", instr_valid, 1'b0);
        @(negedge clk);
        chk1("stale_dropped_valid", instr_valid, 1'b0);
        chk1("redirect_req", imem.req, 1'b1);
        chk16("redirect_addr", imem.addr, 16'h0040);
        @(negedge clk);
        @(negedge clk); chk_ifid("target_load", 16'h1040, 16'h0040, 1'b1);

        // Branch and hazard together: flush wins
        wait_grant(16'h0041);
        brTaken         = 1'b1;
        hazard_detected = 1'b1;
        br_target       = 16'h0080;
        tick();
        brTaken         = 1'b0;
        hazard_detected = 1'b0;
        @(negedge clk);
        chk1("br_haz_valid", instr_valid, 1'b0);
        chk16("br_haz_instr", instruction, 16'h0000);
        chk16("br_haz_addr", imem.addr, 16'h0080);
        @(negedge clk);
        @(negedge clk); chk_ifid("br_haz_load", 16'h1080, 16'h0080, 1'b1);

        // Delayed grant with wrap at 16'hFFFF
        gnt_wait = 4;
        wait_grant(16'h0081);
        brTaken   = 1'b1;
        br_target = 16'hFFFF;
        tick();
        brTaken = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk1("delay_req", imem.req, 1'b1);
            chk16("delay_addr", imem.addr, 16'hFFFF);
            tick();
        end
        wait_grant(16'hFFFF);
        @(negedge clk); chk1("wrap_wait_valid", instr_valid, 1'b0);
        @(negedge clk);
        chk_ifid("wrap_load", 16'h0FFF, 16'hFFFF, 1'b1);
        chk16("wrap_addr", imem.addr, 16'h0000);

        // Async reset during S_WAIT, late rvalid while in reset
        gnt_wait = 0;
        rv_wait  = 3;
        wait_grant(16'h0000);
        #2 rst = 1'b0;
        #1;
        chk_ifid("async_reset", 16'h0000, 16'h0000, 1'b0);
        chk1("async_reset_req", imem.req, 1'b0);
        @(negedge clk); inject = 1; rv_wait = 0;
        @(negedge clk); inject = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("rerelease_req", imem.req, 1'b1);
        chk16("rerelease_addr", imem.addr, 16'h0000);
        chk1("late_rvalid_ignored", instr_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); chk_ifid("post_reset_load", 16'h1000, 16'h0000, 1'b1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
